// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/grant/response,
// and the valid/ready path to decode.
interface if_fetch_queue_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [ILEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_npc;
    logic [ILEN-1:0] id_last_inst;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_inst, id_pc, id_npc, id_last_inst
    );
    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_npc, id_last_inst
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch with a credit-limited prefetch FIFO; redirect flushes the queue and
// discards every response still owed for pre-redirect requests.
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [ILEN-1:0] BUBBLE   = {ILEN{1'b1}}
) (
    input logic             clk,
    input logic             rst,
    if_fetch_queue_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0]            fetch_pc_q, fetch_pc_d;
    logic [DEPTH-1:0][ILEN-1:0] inst_q;
    logic [DEPTH-1:0][XLEN-1:0] pc_q;
    logic [DEPTH-1:0][XLEN-1:0] tag_q;
    ptr_t                       rd_q, rd_d, wr_q, wr_d, trd_q, trd_d, twr_q, twr_d;
    cnt_t                       cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
    logic [ILEN-1:0]            last_q, last_d;
    logic [CW:0]                credits;
    logic                       grant, drop, push, pop;

    // Buffered plus outstanding entries never exceed DEPTH, so a response always has a slot.
    assign credits       = {1'b0, cnt_q} + {1'b0, out_q};
    assign bus.imem_req  = !bus.redirect && (credits < (CW+1)'(DEPTH));
    assign bus.imem_addr = fetch_pc_q;
    assign grant         = bus.imem_req && bus.imem_gnt;
    assign drop          = bus.imem_rvalid && ((drop_q != '0) || bus.redirect);
    assign push          = bus.imem_rvalid && !drop;
    assign pop           = (cnt_q != '0) && bus.id_ready;

    assign bus.id_valid     = (cnt_q != '0);
    assign bus.id_inst      = inst_q[rd_q];
    assign bus.id_pc        = pc_q[rd_q];
    assign bus.id_npc       = pc_q[rd_q] + XLEN'(PC_STEP);
    assign bus.id_last_inst = last_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        trd_d      = trd_q;
        twr_d      = twr_q;
        drop_d     = drop_q;
        last_d     = last_q;
        out_d      = out_q + cnt_t'(grant) - cnt_t'(bus.imem_rvalid);
        cnt_d      = cnt_q + cnt_t'(push) - cnt_t'(pop);
        if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            twr_d      = twr_q + ptr_t'(1);
        end
        // Dropped responses still retire their address tag so tags stay aligned.
        if (bus.imem_rvalid) trd_d = trd_q + ptr_t'(1);
        if (drop && drop_q != '0) drop_d = drop_q - cnt_t'(1);
        if (push) wr_d = wr_q + ptr_t'(1);
        if (pop) begin
            rd_d   = rd_q + ptr_t'(1);
            last_d = inst_q[rd_q];
        end
        if (bus.redirect) begin
            // Everything still owed after this cycle's response predates the redirect.
            fetch_pc_d = bus.redirect_pc;
            rd_d       = '0;
            wr_d       = '0;
            cnt_d      = '0;
            drop_d     = out_q - cnt_t'(bus.imem_rvalid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_q       <= '0;
            wr_q       <= '0;
            trd_q      <= '0;
            twr_q      <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            last_q     <= BUBBLE;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            trd_q      <= trd_d;
            twr_q      <= twr_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            last_q     <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) tag_q[twr_q] <= fetch_pc_q;
        if (push) begin
            inst_q[wr_q] <= bus.imem_rdata;
            pc_q[wr_q]   <= tag_q[trd_q];
        end
    end
endmodule
